// File: rtl/decode_writeback_pkg.sv
// rtl/decode_writeback_pkg.sv - Y86-64 icode and register constants shared by fetch/decode/execute
package decode_writeback_pkg;

   typedef logic [3:0] icode_t;
   typedef logic [3:0] regid_t;

   localparam icode_t HALT   = 4'h0;
   localparam icode_t NOP    = 4'h1;
   localparam icode_t CMOVXX = 4'h2;
   localparam icode_t IRMOVQ = 4'h3;
   localparam icode_t RMMOVQ = 4'h4;
   localparam icode_t MRMOVQ = 4'h5;
   localparam icode_t OPQ    = 4'h6;
   localparam icode_t JXX    = 4'h7;
   localparam icode_t CALL   = 4'h8;
   localparam icode_t RET    = 4'h9;
   localparam icode_t PUSHQ  = 4'hA;
   localparam icode_t POPQ   = 4'hB;

   localparam regid_t REG_RSP  = 4'h4;
   localparam regid_t REG_NONE = 4'hF;

   localparam int NUM_REGS = 15;
   localparam int WORD_W   = 64;

   typedef struct packed {
      regid_t src_a;
      regid_t src_b;
      regid_t dst_e;
      regid_t dst_m;
   } regsel_t;

endpackage

// File: rtl/decode_writeback_regfile.sv
// rtl/decode_writeback_regfile.sv - 15 x 64 register file, two read ports, debug read, two write ports
// Port M is applied after port E so a shared destination keeps the memory value.
module regfile
   import decode_writeback_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  regid_t            ra_addr_i,
   output logic [WORD_W-1:0] ra_data_o,
   input  regid_t            rb_addr_i,
   output logic [WORD_W-1:0] rb_data_o,
   input  regid_t            dbg_addr_i,
   output logic [WORD_W-1:0] dbg_data_o,
   input  regid_t            we_addr_i,
   input  logic [WORD_W-1:0] we_data_i,
   input  regid_t            wm_addr_i,
   input  logic [WORD_W-1:0] wm_data_i
);

   logic [WORD_W-1:0] regs_q [NUM_REGS];
   logic [WORD_W-1:0] regs_d [NUM_REGS];

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (we_addr_i != REG_NONE) begin
         regs_d[we_addr_i] = we_data_i;
      end
      if (wm_addr_i != REG_NONE) begin
         regs_d[wm_addr_i] = wm_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Register F has no storage; reads of it (and any read during reset) return zero.
   assign ra_data_o  = (rst_i || ra_addr_i  == REG_NONE) ? '0 : regs_q[ra_addr_i];
   assign rb_data_o  = (rst_i || rb_addr_i  == REG_NONE) ? '0 : regs_q[rb_addr_i];
   assign dbg_data_o = (rst_i || dbg_addr_i == REG_NONE) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/decode_writeback.sv
// rtl/decode_writeback.sv - Y86-64 decode (source select/read) and writeback (destination select/write)
module decode_writeback
   import decode_writeback_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        icode,
   input  logic [3:0]        rA,
   input  logic [3:0]        rB,
   input  logic [WORD_W-1:0] valE,
   input  logic [WORD_W-1:0] valM,
   input  logic              Cnd,
   output logic [WORD_W-1:0] valA,
   output logic [WORD_W-1:0] valB,
   input  logic [3:0]        dbg_sel,
   output logic [WORD_W-1:0] dbg_val
);

   regsel_t sel;

   always_comb begin
      sel = '{src_a: REG_NONE, src_b: REG_NONE, dst_e: REG_NONE, dst_m: REG_NONE};
      case (icode)
         CMOVXX: begin
            sel.src_a = rA;
            // A failed condition turns cmovXX into a no-write.
            sel.dst_e = Cnd ? rB : REG_NONE;
         end
         IRMOVQ: begin
            sel.dst_e = rB;
         end
         RMMOVQ: begin
            sel.src_a = rA;
            sel.src_b = rB;
         end
         MRMOVQ: begin
            sel.src_b = rB;
            sel.dst_m = rA;
         end
         OPQ: begin
            sel.src_a = rA;
            sel.src_b = rB;
            sel.dst_e = rB;
         end
         CALL: begin
            sel.src_b = REG_RSP;
            sel.dst_e = REG_RSP;
         end
         RET: begin
            sel.src_a = REG_RSP;
            sel.src_b = REG_RSP;
            sel.dst_e = REG_RSP;
         end
         PUSHQ: begin
            sel.src_a = rA;
            sel.src_b = REG_RSP;
            sel.dst_e = REG_RSP;
         end
         POPQ: begin
            sel.src_a = REG_RSP;
            sel.src_b = REG_RSP;
            sel.dst_e = REG_RSP;
            sel.dst_m = rA;
         end
         default: begin
            sel = '{src_a: REG_NONE, src_b: REG_NONE, dst_e: REG_NONE, dst_m: REG_NONE};
         end
      endcase
   end

   regfile u_regfile (
      .clk_i      (clk),
      .rst_i      (reset),
      .ra_addr_i  (sel.src_a),
      .ra_data_o  (valA),
      .rb_addr_i  (sel.src_b),
      .rb_data_o  (valB),
      .dbg_addr_i (dbg_sel),
      .dbg_data_o (dbg_val),
      .we_addr_i  (sel.dst_e),
      .we_data_i  (valE),
      .wm_addr_i  (sel.dst_m),
      .wm_data_i  (valM)
   );

endmodule

// File: tb/tb_decode_writeback.sv
// tb/tb_decode_writeback.sv - directed and random checks of decode_writeback against a register-array model
module tb_decode_writeback;

   logic        clk;
   logic        reset;
   logic [3:0]  icode;
   logic [3:0]  rA;
   logic [3:0]  rB;
   logic [63:0] valE;
   logic [63:0] valM;
   logic        Cnd;
   logic [63:0] valA;
   logic [63:0] valB;
   logic [3:0]  dbg_sel;
   logic [63:0] dbg_val;

   int tests;
   int fails;
   logic [63:0] m_regs [15];

   decode_writeback dut (
      .clk     (clk),
      .reset   (reset),
      .icode   (icode),
      .rA      (rA),
      .rB      (rB),
      .valE    (valE),
      .valM    (valM),
      .Cnd     (Cnd),
      .valA    (valA),
      .valB    (valB),
      .dbg_sel (dbg_sel),
      .dbg_val (dbg_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int m_src_a(input int ic, input int a);
      if (ic inside {2, 4, 6, 10}) return a;
      if (ic inside {9, 11}) return 4;
      return 15;
   endfunction

   function automatic int m_src_b(input int ic, input int b);
      if (ic inside {4, 5, 6}) return b;
      if (ic inside {8, 9, 10, 11}) return 4;
      return 15;
   endfunction

   function automatic int m_dst_e(input int ic, input int b, input int c);
      if (ic inside {3, 6}) return b;
      if (ic == 2 && c == 1) return b;
      if (ic inside {8, 9, 10, 11}) return 4;
      return 15;
   endfunction

   function automatic int m_dst_m(input int ic, input int a);
      if (ic inside {5, 11}) return a;
      return 15;
   endfunction

   function automatic logic [63:0] m_read(input int r);
      if (r == 15) return 64'h0;
      return m_regs[r];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reg(input string tag, input int r, input logic [63:0] exp);
      dbg_sel = 4'(r);
      #1;
      check(tag, dbg_val, exp);
   endtask

   // Executes one instruction across one rising edge; entered and left between edges.
   task automatic run(input int ic, input int a, input int b,
                      input logic [63:0] ve, input logic [63:0] vm, input int c);
      int de, dm, probe;
      icode = 4'(ic); rA = 4'(a); rB = 4'(b); valE = ve; valM = vm; Cnd = c[0];
      #1;
      check("valA", valA, m_read(m_src_a(ic, a)));
      check("valB", valB, m_read(m_src_b(ic, b)));
      de = m_dst_e(ic, b, c);
      dm = m_dst_m(ic, a);
      @(posedge clk);
      if (de != 15) m_regs[de] = ve;
      if (dm != 15) m_regs[dm] = vm;
      #1;
      icode = 4'h1;
      if (de != 15) check_reg("dstE_rd", de, m_regs[de]);
      if (dm != 15) check_reg("dstM_rd", dm, m_regs[dm]);
      probe = int'($urandom_range(0, 14));
      check_reg("probe_rd", probe, m_regs[probe]);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      for (int i = 0; i < 15; i++) m_regs[i] = 64'h0;
      reset = 1'b1;
      icode = 4'h1; rA = 4'hF; rB = 4'hF; valE = '0; valM = '0; Cnd = 1'b0;
      dbg_sel = 4'hF;
      #2;
      check("rst_dbgF", dbg_val, 64'h0);
      check("rst_valA", valA, 64'h0);
      check("rst_valB", valB, 64'h0);
      for (int i = 0; i < 15; i++) check_reg("rst_reg", i, 64'h0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      run(3, 15, 2, 64'h10, 64'h0, 0);
      check_reg("irmovq_r2", 2, 64'h10);

      run(3, 15, 3, 64'h5, 64'h0, 0);
      icode = 4'h6; rA = 4'h2; rB = 4'h3;
      #1;
      check("opq_valA", valA, 64'h10);
      check("opq_valB", valB, 64'h5);
      run(6, 2, 3, 64'h15, 64'h0, 0);
      check_reg("opq_r3", 3, 64'h15);

      run(2, 3, 1, 64'h7, 64'h0, 0);
      check_reg("cmov_nc_r1", 1, 64'h0);
      run(2, 3, 1, 64'h7, 64'h0, 1);
      check_reg("cmov_c_r1", 1, 64'h7);

      run(11, 4, 15, 64'h108, 64'hAA, 0);
      check_reg("popq_rsp", 4, 64'hAA);

      icode = 4'hA; rA = 4'h0; rB = 4'hF;
      #1;
      check("pushq_valB", valB, 64'hAA);
      run(10, 0, 15, 64'hAA - 64'h8, 64'h0, 0);
      check_reg("pushq_r4", 4, 64'hA2);
      check_reg("pushq_r0", 0, 64'h0);

      check_reg("dbg_none", 15, 64'h0);

      for (int n = 0; n < 300; n++) begin
         run(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 15; i++) check_reg("sweep", i, m_regs[i]);

      reset = 1'b1;
      for (int i = 0; i < 15; i++) check_reg("midrst_reg", i, 64'h0);
      icode = 4'h3; rA = 4'hF; rB = 4'h5; valE = 64'hDEAD;
      @(posedge clk);
      #1;
      icode = 4'h1;
      check_reg("midrst_nowr", 5, 64'h0);
      icode = 4'h6; rA = 4'h2; rB = 4'h3;
      #1;
      check("midrst_valA", valA, 64'h0);
      check("midrst_valB", valB, 64'h0);
      icode = 4'h1;
      reset = 1'b0;
      for (int i = 0; i < 15; i++) m_regs[i] = 64'h0;
      run(3, 15, 5, 64'h77, 64'h0, 0);
      check_reg("postrst_r5", 5, 64'h77);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/decode_writeback.md
DECODE_WRITEBACK -- requirements
Module: decode_writeback

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port icode, input, 4 bits: Y86-64 instruction code of the current instruction.
REQ-004 SHALL have port rA, input, 4 bits: first register specifier; 4'hF means none.
REQ-005 SHALL have port rB, input, 4 bits: second register specifier; 4'hF means none.
REQ-006 SHALL have port valE, input, 64 bits: execute-stage result to write back.
REQ-007 SHALL have port valM, input, 64 bits: memory-stage read data to write back.
REQ-008 SHALL have port Cnd, input, 1 bit: condition flag from the execute stage; qualifies cmovXX writeback.
REQ-009 SHALL have port valA, output, 64 bits: operand A read for the execute stage.
REQ-010 SHALL have port valB, output, 64 bits: operand B read for the execute stage.
REQ-011 SHALL have port dbg_sel, input, 4 bits: debug register index.
REQ-012 SHALL have port dbg_val, output, 64 bits: contents of register dbg_sel; returns 0 when dbg_sel = 4'hF.

Function
REQ-013 SHALL hold a 15 x 64-bit register file, indices 0-14; index 4 is %rsp; index F is never stored.
REQ-014 SHALL select srcA as follows: rA for icode 2, 4, 6 and A; 4 for icode 9 and B; F otherwise.
REQ-015 SHALL select srcB as follows: rB for icode 4, 5 and 6; 4 for icode 8, 9, A and B; F otherwise.
REQ-016 SHALL drive valA and valB combinationally from the current register contents; a source of F yields 0.
REQ-017 SHALL select dstE as follows: rB for icode 3 and 6; rB for icode 2 only when Cnd=1; 4 for icode 8, 9, A and B; F otherwise.
REQ-018 SHALL select dstM as follows: rA for icode 5 and B; F otherwise.
REQ-019 SHALL, on the rising clk edge, write valE to dstE and valM to dstM; a destination of F writes nothing.
REQ-020 SHALL, when dstE = dstM (e.g. popq %rsp), store valM only.
REQ-021 SHALL make a write visible on valA/valB/dbg_val only after the clock edge that performs it; there is no same-cycle bypass.
REQ-022 SHALL write nothing for icode 0, 1, 7 or any undefined icode (C-F).
REQ-023 SHALL, when cmovXX has Cnd=0, leave rB unchanged.

Reset
REQ-024 SHALL clear all 15 registers to 0 immediately when reset=1, regardless of clk.
REQ-025 SHALL suppress writes on any clock edge while reset=1; the first write occurs on the first rising edge after reset=0.
REQ-026 SHALL drive valA=valB=dbg_val=0 during reset.

Structure
REQ-027 SHALL take the icode constants (HALT..POPQ), REG_RSP=4 and REG_NONE=F from a shared package also used by the fetch and execute stages.
REQ-028 SHALL instantiate one sub-module, regfile, with two combinational read ports, two synchronous write ports and asynchronous clear; the src/dst selection logic lives in decode_writeback.

Verification
REQ-029 SHALL cover: reset, then irmovq (icode 3, rB=2, valE=64'h10) -> after the edge, dbg_sel=2 reads 64'h10.
REQ-030 SHALL cover: OPq (icode 6, rA=2, rB=3) with r2=64'h10, r3=64'h5 -> valA=64'h10, valB=64'h5 combinationally; valE=64'h15 written to r3 at the next edge.
REQ-031 SHALL cover: cmovXX (icode 2, rB=1, valE=64'h7) with Cnd=0 -> r1 unchanged; repeated with Cnd=1 -> r1=64'h7.
REQ-032 SHALL cover: popq %rsp (icode B, rA=4, valE=64'h108, valM=64'hAA) -> r4=64'hAA after the edge.
REQ-033 SHALL cover: pushq (icode A, rA=0) -> valB equals r4; valE=r4-8 written to r4; r0 unchanged.
REQ-034 SHALL cover: reset asserted mid-sequence between edges -> all dbg_val reads return 0 immediately; the write on the next edge is suppressed while reset=1.
